// File: rtl/psum_accum_buffer.sv
// Purpose: accumulates PE-array partial sums into an on-chip RAM (read-modify-write), then drains them in address order.
// Latency: RAM is updated 2 cycles after valid_i; the first drained word appears 3 cycles after done_i at most.
// Backpressure: the drain holds out_valid_o/out_data_o/out_last_o until out_ready_i; valid_i is dropped in FLUSH/DRAIN.
// Ports: clk_i/rst_ni (async active-low); valid_i/write_addr_i/psum_i/first_pass_i accumulate beat;
//        done_i/drain_len_i start a drain of words 0..drain_len_i-1; out_valid_o/out_ready_i/out_data_o/out_last_o
//        drain stream; busy_o is high outside IDLE.
// Build option: PSUM_RELU_EN clamps negative drained words to 0 (stored sums are untouched).
module psum_accum_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] write_addr_i,
    input  logic [DATA_W-1:0] psum_i,
    input  logic              first_pass_i,
    input  logic              done_i,
    input  logic [ADDR_W-1:0] drain_len_i,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Stage 1 registers: beat captured together with the RAM word (or forwarded sum) it accumulates onto.
    logic              s1_vld;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_psum;
    logic              s1_first;
    logic [DATA_W-1:0] s1_rd;

    logic [DATA_W:0]   wide;
    logic [DATA_W-1:0] sat;
    logic [DATA_W-1:0] sum;

    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] dptr_q;
    logic              issued_all_q;

    // Two-entry skid buffer between the drain read and the output port.
    logic [DATA_W-1:0] ent_dat [2];
    logic              ent_last [2];
    logic              wr_idx_q;
    logic              rd_idx_q;
    logic [1:0]        cnt_q;

    logic              accept;
    logic              done_take;
    logic              fwd;
    logic              pop;
    logic              can_push;
    logic              issue;
    logic              is_last;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] drain_word;

    assign accept    = valid_i && (state_q == IDLE || state_q == ACCUM);
    assign done_take = done_i && (state_q == IDLE || state_q == ACCUM);
    // The beat being written this cycle is not yet visible in the RAM; hand its sum straight to the next beat.
    assign fwd       = accept && s1_vld && (write_addr_i == s1_addr);
    assign pop       = out_valid_o && out_ready_i;
    assign can_push  = (cnt_q != 2'd2) || pop;
    // The first drain read is issued from FLUSH on the cycle the pipeline is empty, so it follows the final write.
    assign issue     = can_push &&
                       ((state_q == FLUSH && !s1_vld && len_q != '0) ||
                        (state_q == DRAIN && !issued_all_q));
    assign is_last   = (dptr_q == len_q - ADDR_W'(1));

    // Accumulate and drain never read in the same cycle, so one read port serves both.
    assign rd_addr   = accept ? write_addr_i : dptr_q;
    assign rd_word   = mem[rd_addr];

`ifdef PSUM_RELU_EN
    assign drain_word = rd_word[DATA_W-1] ? '0 : rd_word;
`else
    assign drain_word = rd_word;
`endif

    // Sign-extended add one bit wider; an overflow shows up as differing top two bits.
    assign wide = {s1_rd[DATA_W-1], s1_rd} + {s1_psum[DATA_W-1], s1_psum};

    always_comb begin
        sat = wide[DATA_W-1:0];
        if (wide[DATA_W] != wide[DATA_W-1]) begin
            sat = wide[DATA_W] ? SAT_MIN : SAT_MAX;
        end
        sum = s1_first ? s1_psum : sat;
    end

    always_ff @(posedge clk_i) begin
        if (s1_vld) begin
            mem[s1_addr] <= sum;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld   <= 1'b0;
            s1_addr  <= '0;
            s1_psum  <= '0;
            s1_first <= 1'b0;
            s1_rd    <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_addr  <= write_addr_i;
                s1_psum  <= psum_i;
                s1_first <= first_pass_i;
                s1_rd    <= fwd ? sum : rd_word;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q        <= '0;
            dptr_q       <= '0;
            issued_all_q <= 1'b0;
            ent_dat[0]   <= '0;
            ent_dat[1]   <= '0;
            ent_last[0]  <= 1'b0;
            ent_last[1]  <= 1'b0;
            wr_idx_q     <= 1'b0;
            rd_idx_q     <= 1'b0;
            cnt_q        <= 2'd0;
        end else begin
            if (done_take) begin
                len_q        <= drain_len_i;
                dptr_q       <= '0;
                issued_all_q <= 1'b0;
            end else if (issue) begin
                dptr_q <= dptr_q + ADDR_W'(1);
                if (is_last) begin
                    issued_all_q <= 1'b1;
                end
            end
            if (issue) begin
                ent_dat[wr_idx_q]  <= drain_word;
                ent_last[wr_idx_q] <= is_last;
                wr_idx_q           <= ~wr_idx_q;
            end
            if (pop) begin
                rd_idx_q <= ~rd_idx_q;
            end
            case ({issue, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (done_i) begin
                    state_d = FLUSH;
                end else if (valid_i) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (done_i) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!s1_vld) begin
                    state_d = (len_q == '0) ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last_o) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = out_valid_o ? ent_dat[rd_idx_q] : '0;
    assign out_last_o  = out_valid_o && ent_last[rd_idx_q];
    assign busy_o      = (state_q != IDLE);

endmodule
